// File: rtl/axil_resp_pkg.sv
// Shared types for the AXI4-Lite BRAM responder: response codes, FSM encodings,
// the latched write-beat payload and the address range check.
package axil_resp_pkg;

  localparam int unsigned AXIL_DATA_W = 32;
  localparam int unsigned AXIL_STRB_W = AXIL_DATA_W / 8;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE,
    W_HAVE_AW,
    W_HAVE_W,
    W_RESP
  } wr_state_t;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } rd_state_t;

  typedef struct packed {
    logic [AXIL_DATA_W-1:0] data;
    logic [AXIL_STRB_W-1:0] strb;
  } wr_beat_t;

  // True when a byte offset falls inside the RAM backing the window.
  function automatic logic in_range(input logic [31:0] byte_addr,
                                    input logic [31:0] depth_words);
    return byte_addr < (depth_words << 2);
  endfunction

endpackage

// File: rtl/axil_flood_guard.sv
// Write flood guard: counts AW accepts per window and holds a penalty when the
// threshold is hit. Exists only when AXIL_FLOOD_GUARD_EN is defined.
`ifdef AXIL_FLOOD_GUARD_EN
module axil_flood_guard #(
  parameter int unsigned FG_WINDOW  = 256,
  parameter int unsigned FG_THRESH  = 64,
  parameter int unsigned FG_PENALTY = 512
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic aw_hs_i,
  output logic flood_active_o,
  output logic flood_next_c
);

  localparam int unsigned WIN_W = $clog2(FG_WINDOW);
  localparam int unsigned CNT_W = $clog2(FG_THRESH + 1);
  localparam int unsigned PEN_W = $clog2(FG_PENALTY);

  logic [WIN_W-1:0] win_q, win_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [PEN_W-1:0] pen_q, pen_d;
  logic             flood_q, flood_d;

  // Window/count are frozen at zero during the penalty and restart after it.
  always_comb begin : guard_next
    win_d   = win_q;
    cnt_d   = cnt_q;
    pen_d   = pen_q;
    flood_d = flood_q;
    cnt_inc = cnt_q + CNT_W'(aw_hs_i);
    if (flood_q) begin
      if (pen_q == '0) begin
        flood_d = 1'b0;
        win_d   = '0;
        cnt_d   = '0;
      end else begin
        pen_d = pen_q - PEN_W'(1);
      end
    end else if (cnt_inc == CNT_W'(FG_THRESH)) begin
      flood_d = 1'b1;
      pen_d   = PEN_W'(FG_PENALTY - 1);
      win_d   = '0;
      cnt_d   = '0;
    end else if (win_q == WIN_W'(FG_WINDOW - 1)) begin
      win_d = '0;
      cnt_d = '0;
    end else begin
      win_d = win_q + WIN_W'(1);
      cnt_d = cnt_inc;
    end
  end

  always_ff @(posedge clk_i) begin : guard_regs
    if (rst_i) begin
      win_q   <= '0;
      cnt_q   <= '0;
      pen_q   <= '0;
      flood_q <= 1'b0;
    end else begin
      win_q   <= win_d;
      cnt_q   <= cnt_d;
      pen_q   <= pen_d;
      flood_q <= flood_d;
    end
  end

  assign flood_active_o = flood_q;
  assign flood_next_c   = flood_d;

endmodule
`endif

// File: rtl/axil_bram_responder.sv
// AXI4-Lite slave fronting an inferred word RAM with byte-strobed writes,
// registered reads and saturating counters. AXIL_FLOOD_GUARD_EN adds AW throttling.
module axil_bram_responder
  import axil_resp_pkg::*;
#(
  parameter int unsigned ADDR_W      = 14,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned DEPTH_WORDS = 2048
`ifdef AXIL_FLOOD_GUARD_EN
  ,
  parameter int unsigned FG_WINDOW   = 256,
  parameter int unsigned FG_THRESH   = 64,
  parameter int unsigned FG_PENALTY  = 512
`endif
) (
  input  logic                clk_100MHz,
  input  logic                reset_rtl_0,
  input  logic [ADDR_W-1:0]   s_axi_awaddr,
  input  logic [2:0]          s_axi_awprot,
  input  logic                s_axi_awvalid,
  output logic                s_axi_awready,
  input  logic [DATA_W-1:0]   s_axi_wdata,
  input  logic [DATA_W/8-1:0] s_axi_wstrb,
  input  logic                s_axi_wvalid,
  output logic                s_axi_wready,
  output logic [1:0]          s_axi_bresp,
  output logic                s_axi_bvalid,
  input  logic                s_axi_bready,
  input  logic [ADDR_W-1:0]   s_axi_araddr,
  input  logic [2:0]          s_axi_arprot,
  input  logic                s_axi_arvalid,
  output logic                s_axi_arready,
  output logic [DATA_W-1:0]   s_axi_rdata,
  output logic [1:0]          s_axi_rresp,
  output logic                s_axi_rvalid,
  input  logic                s_axi_rready,
  output logic [31:0]         wr_count,
  output logic [31:0]         rd_count,
  output logic [15:0]         err_count,
  output logic                flood_active
);

  localparam int unsigned IDX_W  = $clog2(DEPTH_WORDS);
  localparam int unsigned STRB_W = DATA_W / 8;

  wr_state_t wr_state_q, wr_state_d;
  rd_state_t rd_state_q, rd_state_d;

  logic [ADDR_W-1:0] aw_addr_q, aw_addr_eff;
  wr_beat_t          wbeat_q, wbeat_eff;

  logic awready_q, awready_d, wready_q, wready_d;
  logic bvalid_q, bvalid_d, arready_q, arready_d, rvalid_q, rvalid_d;
  logic [1:0] bresp_q, bresp_d, rresp_q, rresp_d;
  logic [DATA_W-1:0] rdata_q;
  logic [31:0] wr_count_q, wr_count_d, rd_count_q, rd_count_d;
  logic [15:0] err_count_q, err_count_d;
  logic [1:0]  err_inc;
  logic [16:0] err_sum;

  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic wr_ok, rd_ok, wr_commit, ram_we;
  logic throttle_next;
  logic unused_ok;

  logic [DATA_W-1:0] mem_q [DEPTH_WORDS];

  assign aw_hs = s_axi_awvalid && awready_q;
  assign w_hs  = s_axi_wvalid  && wready_q;
  assign b_hs  = bvalid_q && s_axi_bready;
  assign ar_hs = s_axi_arvalid && arready_q;
  assign r_hs  = rvalid_q && s_axi_rready;

  // A beat arriving this cycle takes priority over the held copy.
  assign aw_addr_eff = aw_hs ? s_axi_awaddr : aw_addr_q;
  assign wbeat_eff   = w_hs ? '{data: s_axi_wdata, strb: s_axi_wstrb} : wbeat_q;

  assign wr_ok = in_range(32'(aw_addr_eff), 32'(DEPTH_WORDS));
  assign rd_ok = in_range(32'(s_axi_araddr), 32'(DEPTH_WORDS));

  assign unused_ok = ^{s_axi_awprot, s_axi_arprot};

`ifdef AXIL_FLOOD_GUARD_EN
  axil_flood_guard #(
    .FG_WINDOW  (FG_WINDOW),
    .FG_THRESH  (FG_THRESH),
    .FG_PENALTY (FG_PENALTY)
  ) u_flood_guard (
    .clk_i          (clk_100MHz),
    .rst_i          (reset_rtl_0),
    .aw_hs_i        (aw_hs),
    .flood_active_o (flood_active),
    .flood_next_c   (throttle_next)
  );
`else
  assign throttle_next = 1'b0;
  assign flood_active  = 1'b0;
`endif

  // Write FSM: AW and W land independently; the RAM write happens on the cycle both are held.
  always_comb begin : wr_next
    wr_state_d = wr_state_q;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    wr_commit  = 1'b0;
    ram_we     = 1'b0;
    case (wr_state_q)
      W_IDLE: begin
        if (aw_hs && w_hs)  wr_commit  = 1'b1;
        else if (aw_hs)     wr_state_d = W_HAVE_AW;
        else if (w_hs)      wr_state_d = W_HAVE_W;
      end
      W_HAVE_AW: if (w_hs)  wr_commit = 1'b1;
      W_HAVE_W:  if (aw_hs) wr_commit = 1'b1;
      W_RESP: begin
        if (b_hs) begin
          wr_state_d = W_IDLE;
          bvalid_d   = 1'b0;
        end
      end
      default: wr_state_d = W_IDLE;
    endcase
    if (wr_commit) begin
      wr_state_d = W_RESP;
      bvalid_d   = 1'b1;
      bresp_d    = wr_ok ? RESP_OKAY : RESP_SLVERR;
      ram_we     = wr_ok;
    end
    awready_d = ((wr_state_d == W_IDLE) || (wr_state_d == W_HAVE_W)) && !throttle_next;
    wready_d  = (wr_state_d == W_IDLE) || (wr_state_d == W_HAVE_AW);
  end

  always_comb begin : rd_next
    rd_state_d = rd_state_q;
    rvalid_d   = rvalid_q;
    rresp_d    = rresp_q;
    case (rd_state_q)
      R_IDLE: begin
        if (ar_hs) begin
          rd_state_d = R_DATA;
          rvalid_d   = 1'b1;
          rresp_d    = rd_ok ? RESP_OKAY : RESP_SLVERR;
        end
      end
      R_DATA: begin
        if (r_hs) begin
          rd_state_d = R_IDLE;
          rvalid_d   = 1'b0;
        end
      end
      default: rd_state_d = R_IDLE;
    endcase
    arready_d = (rd_state_d == R_IDLE);
  end

  // Saturating traffic counters; both channels may report an error in one cycle.
  always_comb begin : cnt_next
    wr_count_d  = (b_hs && (wr_count_q != '1)) ? wr_count_q + 32'd1 : wr_count_q;
    rd_count_d  = (r_hs && (rd_count_q != '1)) ? rd_count_q + 32'd1 : rd_count_q;
    err_inc     = 2'(b_hs && (bresp_q == RESP_SLVERR)) + 2'(r_hs && (rresp_q == RESP_SLVERR));
    err_sum     = {1'b0, err_count_q} + 17'(err_inc);
    err_count_d = err_sum[16] ? '1 : err_sum[15:0];
  end

  always_ff @(posedge clk_100MHz) begin : ctrl_regs
    if (reset_rtl_0) begin
      wr_state_q  <= W_IDLE;
      rd_state_q  <= R_IDLE;
      awready_q   <= 1'b0;
      wready_q    <= 1'b0;
      bvalid_q    <= 1'b0;
      bresp_q     <= RESP_OKAY;
      arready_q   <= 1'b0;
      rvalid_q    <= 1'b0;
      rresp_q     <= RESP_OKAY;
      rdata_q     <= '0;
      aw_addr_q   <= '0;
      wbeat_q     <= '0;
      wr_count_q  <= '0;
      rd_count_q  <= '0;
      err_count_q <= '0;
    end else begin
      wr_state_q  <= wr_state_d;
      rd_state_q  <= rd_state_d;
      awready_q   <= awready_d;
      wready_q    <= wready_d;
      bvalid_q    <= bvalid_d;
      bresp_q     <= bresp_d;
      arready_q   <= arready_d;
      rvalid_q    <= rvalid_d;
      rresp_q     <= rresp_d;
      wr_count_q  <= wr_count_d;
      rd_count_q  <= rd_count_d;
      err_count_q <= err_count_d;
      if (aw_hs) aw_addr_q <= s_axi_awaddr;
      if (w_hs)  wbeat_q   <= wbeat_eff;
      if (ar_hs) rdata_q   <= rd_ok ? mem_q[s_axi_araddr[IDX_W+1:2]] : '0;
    end
  end

  // RAM contents survive reset; a same-cycle read sees the pre-write word.
  always_ff @(posedge clk_100MHz) begin : ram_write
    if (ram_we) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (wbeat_eff.strb[b]) mem_q[aw_addr_eff[IDX_W+1:2]][8*b +: 8] <= wbeat_eff.data[8*b +: 8];
      end
    end
  end

  assign s_axi_awready = awready_q;
  assign s_axi_wready  = wready_q;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bresp   = bresp_q;
  assign s_axi_arready = arready_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rresp   = rresp_q;
  assign s_axi_rdata   = rdata_q;
  assign wr_count      = wr_count_q;
  assign rd_count      = rd_count_q;
  assign err_count     = err_count_q;

endmodule

// File: tb/tb_axil_bram_responder.sv
// Directed plus randomized bench for axil_bram_responder against an array model
// of the RAM and expected counters. Flood checks run when AXIL_FLOOD_GUARD_EN is defined.
module tb_axil_bram_responder;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  logic        clk = 1'b0;
  logic        reset_rtl_0;
  logic [13:0] s_axi_awaddr, s_axi_araddr;
  logic [2:0]  s_axi_awprot, s_axi_arprot;
  logic        s_axi_awvalid, s_axi_awready, s_axi_wvalid, s_axi_wready;
  logic [31:0] s_axi_wdata, s_axi_rdata;
  logic [3:0]  s_axi_wstrb;
  logic [1:0]  s_axi_bresp, s_axi_rresp;
  logic        s_axi_bvalid, s_axi_bready, s_axi_arvalid, s_axi_arready;
  logic        s_axi_rvalid, s_axi_rready;
  logic [31:0] wr_count, rd_count;
  logic [15:0] err_count;
  logic        flood_active;

  int checks = 0;
  int failures = 0;
  int wr_exp = 0, rd_exp = 0, err_exp = 0;
  bit [31:0] mdl [0:2047];

  always #5 clk = ~clk;

  axil_bram_responder dut (
    .clk_100MHz    (clk),
    .reset_rtl_0   (reset_rtl_0),
    .s_axi_awaddr  (s_axi_awaddr),
    .s_axi_awprot  (s_axi_awprot),
    .s_axi_awvalid (s_axi_awvalid),
    .s_axi_awready (s_axi_awready),
    .s_axi_wdata   (s_axi_wdata),
    .s_axi_wstrb   (s_axi_wstrb),
    .s_axi_wvalid  (s_axi_wvalid),
    .s_axi_wready  (s_axi_wready),
    .s_axi_bresp   (s_axi_bresp),
    .s_axi_bvalid  (s_axi_bvalid),
    .s_axi_bready  (s_axi_bready),
    .s_axi_araddr  (s_axi_araddr),
    .s_axi_arprot  (s_axi_arprot),
    .s_axi_arvalid (s_axi_arvalid),
    .s_axi_arready (s_axi_arready),
    .s_axi_rdata   (s_axi_rdata),
    .s_axi_rresp   (s_axi_rresp),
    .s_axi_rvalid  (s_axi_rvalid),
    .s_axi_rready  (s_axi_rready),
    .wr_count      (wr_count),
    .rd_count      (rd_count),
    .err_count     (err_count),
    .flood_active  (flood_active)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_rd(input logic [13:0] a);
    return (a < 14'h2000) ? mdl[a[12:2]] : 32'h0;
  endfunction

  function automatic logic [1:0] exp_resp(input logic [13:0] a);
    return (a < 14'h2000) ? OKAY : SLVERR;
  endfunction

  task automatic reset_dut(input int n);
    reset_rtl_0   = 1'b1;
    s_axi_awvalid = 1'b0;
    s_axi_wvalid  = 1'b0;
    s_axi_arvalid = 1'b0;
    s_axi_bready  = 1'b0;
    s_axi_rready  = 1'b0;
    repeat (n) @(negedge clk);
    check("rst_valids", 32'({s_axi_bvalid, s_axi_rvalid}), 0);
    check("rst_readies", 32'({s_axi_awready, s_axi_wready, s_axi_arready}), 0);
    check("rst_resp_data", 32'({s_axi_bresp, s_axi_rresp}) | s_axi_rdata, 0);
    check("rst_wr_count", wr_count, 0);
    check("rst_rd_count", rd_count, 0);
    check("rst_err_count", 32'(err_count), 0);
    check("rst_flood", 32'(flood_active), 0);
    reset_rtl_0 = 1'b0;
    @(negedge clk);
    check("rel_readies", 32'({s_axi_awready, s_axi_wready, s_axi_arready}), 7);
    wr_exp = 0; rd_exp = 0; err_exp = 0;
  endtask

  // Starts and ends just after a falling edge.
  task automatic do_write(input logic [13:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int aw_d, input int w_d, input int b_d);
    bit aw_done = 0, w_done = 0, aw_go, w_go;
    int cyc = 0;
    logic [1:0] er;
    er = exp_resp(a);
    s_axi_awaddr = a; s_axi_wdata = d; s_axi_wstrb = s;
    while (!(aw_done && w_done) && cyc < 2000) begin
      s_axi_awvalid = !aw_done && (cyc >= aw_d);
      s_axi_wvalid  = !w_done && (cyc >= w_d);
      aw_go = s_axi_awvalid && s_axi_awready;
      w_go  = s_axi_wvalid && s_axi_wready;
      @(negedge clk);
      aw_done |= aw_go;
      w_done  |= w_go;
      cyc++;
    end
    s_axi_awvalid = 1'b0;
    s_axi_wvalid  = 1'b0;
    check("wr_handshake", 32'({aw_done, w_done}), 3);
    check("bvalid", 32'(s_axi_bvalid), 1);
    check("bresp", 32'(s_axi_bresp), 32'(er));
    check("wresp_readies", 32'({s_axi_awready, s_axi_wready}), 0);
    if (er == OKAY)
      for (int b = 0; b < 4; b++) if (s[b]) mdl[a[12:2]][8*b +: 8] = d[8*b +: 8];
    repeat (b_d) begin
      @(negedge clk);
      check("bvalid_hold", 32'({s_axi_bvalid, s_axi_bresp}), 32'({1'b1, er}));
    end
    s_axi_bready = 1'b1;
    @(negedge clk);
    s_axi_bready = 1'b0;
    wr_exp++;
    if (er == SLVERR) err_exp++;
    check("bvalid_clr", 32'(s_axi_bvalid), 0);
    check("wr_count", wr_count, 32'(wr_exp));
    check("err_count_w", 32'(err_count), 32'(err_exp));
  endtask

  task automatic do_read(input logic [13:0] a, input logic [31:0] ed, input logic [1:0] er,
                         input int r_d);
    bit done = 0;
    int cyc = 0;
    s_axi_araddr = a;
    while (!done && cyc < 100) begin
      s_axi_arvalid = 1'b1;
      done = s_axi_arready;
      @(negedge clk);
      cyc++;
    end
    s_axi_arvalid = 1'b0;
    check("ar_handshake", 32'(done), 1);
    check("rvalid", 32'(s_axi_rvalid), 1);
    check("rdata", s_axi_rdata, ed);
    check("rresp", 32'(s_axi_rresp), 32'(er));
    repeat (r_d) begin
      @(negedge clk);
      check("r_hold", s_axi_rdata ^ 32'({s_axi_rvalid, s_axi_rresp}), ed ^ 32'({1'b1, er}));
    end
    s_axi_rready = 1'b1;
    @(negedge clk);
    s_axi_rready = 1'b0;
    rd_exp++;
    if (er == SLVERR) err_exp++;
    check("rvalid_clr", 32'(s_axi_rvalid), 0);
    check("rd_count", rd_count, 32'(rd_exp));
    check("err_count_r", 32'(err_count), 32'(err_exp));
  endtask

`ifdef AXIL_FLOOD_GUARD_EN
  int aw_accepts = 0;
  bit fg_done = 0;
  always @(posedge clk) begin
    if (reset_rtl_0) aw_accepts <= 0;
    else if (s_axi_awvalid && s_axi_awready) aw_accepts <= aw_accepts + 1;
  end
`endif

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [13:0] a;
    int sel, idx;
    s_axi_awprot = 3'b000; s_axi_arprot = 3'b000;
    s_axi_awaddr = '0; s_axi_araddr = '0; s_axi_wdata = '0; s_axi_wstrb = '0;

    // Reset held for three cycles, then the first idle cycle.
    reset_dut(3);

    // Basic write then read.
    do_write(14'h0004, 32'hCAFE0001, 4'hF, 0, 0, 0);
    do_read(14'h0004, 32'hCAFE0001, OKAY, 0);

    // W leads AW by four cycles, partial strobe.
    do_write(14'h0004, 32'hBAD00000, 4'h3, 4, 0, 1);
    check("strobe_merge", mdl[1], 32'hCAFE0000);
    do_read(14'h0004, 32'hCAFE0000, OKAY, 2);

    // Out-of-range accesses must not alias onto word 0.
    do_write(14'h0000, 32'h11223344, 4'hF, 0, 0, 0);
    do_write(14'h2000, 32'hDEADBEEF, 4'hF, 0, 0, 0);
    do_read(14'h3FFC, 32'h0, SLVERR, 0);
    check("err_count_two", 32'(err_count), 2);
    do_read(14'h0000, 32'h11223344, OKAY, 0);

    // Last in-range word.
    do_write(14'h1FFC, 32'h5A5A0F0F, 4'hF, 0, 0, 0);
    do_read(14'h1FFC, 32'h5A5A0F0F, OKAY, 0);

    // Same-cycle write and read of one word returns the old value.
    do_write(14'h0050, 32'h01020304, 4'hF, 0, 0, 0);
    fork
      do_write(14'h0050, 32'hA5A5A5A5, 4'hF, 0, 0, 0);
      do_read(14'h0050, 32'h01020304, OKAY, 0);
    join
    do_read(14'h0050, 32'hA5A5A5A5, OKAY, 0);

    // Seed the random address pool, then mixed random traffic.
    for (int i = 0; i < 17; i++) begin
      idx = (i == 16) ? 2047 : i;
      do_write(14'(idx * 4), $urandom, 4'hF, 0, 0, 0);
    end
    for (int i = 0; i < 40; i++) begin
      sel = int'($urandom_range(0, 9));
      if (sel < 8) begin
        idx = int'($urandom_range(0, 16));
        if (idx == 16) idx = 2047;
        a = 14'(idx * 4 + int'($urandom_range(0, 3)));
      end else begin
        a = 14'(32'h2000 + 4 * $urandom_range(0, 2047) + $urandom_range(0, 3));
      end
      if ($urandom_range(0, 1) == 1)
        do_write(a, $urandom, 4'($urandom_range(0, 15)), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
      else
        do_read(a, exp_rd(a), exp_resp(a), int'($urandom_range(0, 2)));
    end
    check("flood_idle", 32'(flood_active), 0);

    // Reset while a B response is pending drops it.
    s_axi_awaddr = 14'(500 * 4); s_axi_wdata = 32'h0BADF00D; s_axi_wstrb = 4'hF;
    s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
    @(negedge clk);
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    check("pend_bvalid", 32'(s_axi_bvalid), 1);
    @(negedge clk);
    check("pend_bvalid_hold", 32'(s_axi_bvalid), 1);
    reset_dut(1);
    do_write(14'h0008, 32'h76543210, 4'hF, 1, 0, 0);
    do_read(14'h0008, 32'h76543210, OKAY, 0);

`ifdef AXIL_FLOOD_GUARD_EN
    // Back-to-back writes trip the guard; reads keep their two-cycle cadence.
    reset_dut(2);
    fork
      begin : fg_writer
        while (!fg_done) do_write(14'(100 * 4), $urandom, 4'hF, 0, 0, 0);
      end
      begin : fg_reader
        int j = 0;
        while (!fg_done) begin
          check("fg_rd_arready", 32'(s_axi_arready), 1);
          do_read(14'((j % 16) * 4), mdl[j % 16], OKAY, 0);
          j++;
        end
      end
      begin : fg_monitor
        int waitc = 0, hi = 0;
        bit leak = 0;
        while (!flood_active && waitc < 400) begin
          @(negedge clk);
          waitc++;
        end
        check("fg_trip", 32'(flood_active), 1);
        check("fg_accepts", 32'(aw_accepts), 64);
        while (flood_active && hi < 600) begin
          if (s_axi_awready) leak = 1;
          hi++;
          @(negedge clk);
        end
        check("fg_awready_low", 32'(leak), 0);
        check("fg_penalty_len", 32'(hi), 512);
        fg_done = 1;
      end
    join
    check("fg_release", 32'(flood_active), 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
